seg_decode_capture: RTL and testbench

SEG_DECODE_CAPTURE -- requirements
Module: seg_decode_capture

---
 rtl/seg_decode_capture.sv | 136 +++++++++++++
 tb/tb_seg_decode_capture.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_decode_capture.sv
// Seven-segment digit capture: waits for a stable active-low pattern, decodes it
// to a hex nibble and assembles pairs of digits into a byte.
module seg_decode_capture #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [6:0] Seg,
    input  logic       Capture,
    input  logic       Clear,
    output logic [3:0] Nibble,
    output logic       Valid,
    output logic       Error,
    output logic [7:0] Byte,
    output logic       ByteValid,
    output logic       Busy
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t     state;
    logic [6:0] sample;
    logic [3:0] stable_cnt;
    logic [7:0] tmo_cnt;
    logic       digit_cnt;

    logic       accept;
    logic       timeout;
    logic [4:0] dec;

    // Returns {legal, value}; the codes are the active-low g..a hex display set.
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'h40: r = {1'b1, 4'h0};
            7'h79: r = {1'b1, 4'h1};
            7'h24: r = {1'b1, 4'h2};
            7'h30: r = {1'b1, 4'h3};
            7'h19: r = {1'b1, 4'h4};
            7'h12: r = {1'b1, 4'h5};
            7'h02: r = {1'b1, 4'h6};
            7'h78: r = {1'b1, 4'h7};
            7'h00: r = {1'b1, 4'h8};
            7'h10: r = {1'b1, 4'h9};
            7'h08: r = {1'b1, 4'hA};
            7'h03: r = {1'b1, 4'hB};
            7'h46: r = {1'b1, 4'hC};
            7'h21: r = {1'b1, 4'hD};
            7'h06: r = {1'b1, 4'hE};
            7'h0E: r = {1'b1, 4'hF};
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    always_comb begin
        accept  = (state == WAIT) && (Seg == sample) &&
                  (stable_cnt == 4'(STABLE_CYCLES - 1));
        timeout = (state == WAIT) && !accept &&
                  (tmo_cnt == 8'(TIMEOUT_CYCLES - 1));
        dec     = seg_decode(sample);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            sample     <= '0;
            stable_cnt <= '0;
            tmo_cnt    <= '0;
            digit_cnt  <= 1'b0;
            Nibble     <= '0;
            Byte       <= '0;
            Valid      <= 1'b0;
            Error      <= 1'b0;
            ByteValid  <= 1'b0;
            Busy       <= 1'b0;
        end else begin
            Valid     <= 1'b0;
            Error     <= 1'b0;
            ByteValid <= 1'b0;

            // Clear comes first so that a same-edge accept lands on a fresh byte.
            if (Clear) begin
                Byte      <= '0;
                digit_cnt <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (Capture) begin
                        state      <= WAIT;
                        sample     <= Seg;
                        stable_cnt <= 4'd1;
                        tmo_cnt    <= 8'd1;
                        Busy       <= 1'b1;
                    end
                end
                WAIT: begin
                    tmo_cnt <= tmo_cnt + 8'd1;
                    if (Seg == sample) begin
                        stable_cnt <= stable_cnt + 4'd1;
                    end else begin
                        sample     <= Seg;
                        stable_cnt <= 4'd1;
                    end

                    if (accept) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                        if (dec[4]) begin
                            Nibble <= dec[3:0];
                            Valid  <= 1'b1;
                            if (Clear || !digit_cnt) begin
                                Byte[7:4] <= dec[3:0];
                                digit_cnt <= 1'b1;
                            end else begin
                                Byte[3:0] <= dec[3:0];
                                digit_cnt <= 1'b0;
                                ByteValid <= 1'b1;
                            end
                        end else begin
                            Error <= 1'b1;
                        end
                    end else if (timeout) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                        Error <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seg_decode_capture.sv
// Directed bench for seg_decode_capture with a scoreboard of expected
// Valid/Error events checked whenever the DUT pulses.
module tb_seg_decode_capture;

    localparam int STABLE  = 4;
    localparam int TIMEOUT = 64;

    localparam logic [6:0] LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    logic       Clock = 1'b0;
    logic       Reset;
    logic [6:0] Seg;
    logic       Capture;
    logic       Clear;
    logic [3:0] Nibble;
    logic       Valid;
    logic       Error;
    logic [7:0] Byte;
    logic       ByteValid;
    logic       Busy;

    typedef struct {
        bit         err;
        logic [3:0] nib;
        logic [7:0] byt;
        bit         bv;
    } exp_t;

    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    logic [3:0] m_nib;
    logic [7:0] m_byte;
    bit         m_cnt;

    seg_decode_capture #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .Clock(Clock), .Reset(Reset), .Seg(Seg), .Capture(Capture), .Clear(Clear),
        .Nibble(Nibble), .Valid(Valid), .Error(Error), .Byte(Byte),
        .ByteValid(ByteValid), .Busy(Busy)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model of one acceptance; pushes the event the DUT must produce.
    task automatic expect_accept(input logic [6:0] s, input bit clr);
        exp_t e;
        int   idx;
        idx = -1;
        for (int i = 0; i < 16; i++) if (LUT[i] == s) idx = i;
        if (clr) begin
            m_byte = 8'h00;
            m_cnt  = 1'b0;
        end
        e.bv = 1'b0;
        if (idx < 0) begin
            e.err = 1'b1;
        end else begin
            e.err = 1'b0;
            m_nib = 4'(idx);
            if (!m_cnt) begin
                m_byte[7:4] = 4'(idx);
                m_cnt = 1'b1;
            end else begin
                m_byte[3:0] = 4'(idx);
                m_cnt = 1'b0;
                e.bv  = 1'b1;
            end
        end
        e.nib = m_nib;
        e.byt = m_byte;
        sb.push_back(e);
    endtask

    task automatic expect_timeout();
        exp_t e;
        e.err = 1'b1;
        e.nib = m_nib;
        e.byt = m_byte;
        e.bv  = 1'b0;
        sb.push_back(e);
    endtask

    // Capture at edge k, expect the pulse right after edge k+n.
    task automatic do_capture(input string tag, input logic [6:0] s, input int n,
                              input logic [6:0] s2, input int sw, input bit alt,
                              input bit hold, input bit clr_last);
        Seg = s;
        Capture = 1'b1;
        @(posedge Clock); #1;
        if (!hold) Capture = 1'b0;
        chk({tag, "_busy_start"}, Busy, 1);
        for (int j = 1; j <= n; j++) begin
            if (alt) Seg = (Seg == 7'h40) ? 7'h79 : 7'h40;
            if (j == sw) Seg = s2;
            if (clr_last && j == n) Clear = 1'b1;
            @(posedge Clock); #1;
            Clear = 1'b0;
            if (j < n) begin
                chk({tag, "_busy_wait"}, Busy, 1);
                chk({tag, "_early_pulse"}, Valid | Error, 0);
            end else begin
                chk({tag, "_busy_done"}, Busy, 0);
                chk({tag, "_pulse"}, Valid | Error, 1);
            end
        end
        Capture = 1'b0;
        @(posedge Clock); #1;
        chk({tag, "_pulse_end"}, Valid | Error | ByteValid, 0);
        chk({tag, "_idle"}, Busy, 0);
    endtask

    always @(negedge Clock) begin
        exp_t e;
        if (Valid === 1'b1 || Error === 1'b1) begin
            chk("event_expected", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("valid", Valid, !e.err);
                chk("error", Error, e.err);
                chk("nibble", Nibble, e.nib);
                chk("byte", Byte, e.byt);
                chk("bytevalid", ByteValid, e.bv);
            end
        end else if (Reset === 1'b0) begin
            chk("bytevalid_alone", ByteValid, 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        m_nib = 4'h0; m_byte = 8'h00; m_cnt = 1'b0;
        Seg = 7'h7F; Capture = 1'b0; Clear = 1'b0;
        Reset = 1'b0;
        #2 Reset = 1'b1;
        #2;
        chk("rst_nibble", Nibble, 0);
        chk("rst_byte", Byte, 0);
        chk("rst_pulses", {Valid, Error, ByteValid}, 0);
        chk("rst_busy", Busy, 0);
        @(posedge Clock); #1;
        @(posedge Clock); #1;
        Reset = 1'b0;
        @(posedge Clock); #1;

        expect_accept(7'h24, 0);
        do_capture("dig2", 7'h24, STABLE - 1, 7'h24, 0, 0, 0, 0);
        chk("dig2_byte", Byte, 8'h20);

        expect_accept(7'h0E, 0);
        do_capture("digF", 7'h0E, STABLE - 1, 7'h0E, 0, 0, 0, 0);
        chk("digF_byte", Byte, 8'h2F);

        expect_accept(7'h7F, 0);
        do_capture("blank", 7'h7F, STABLE - 1, 7'h7F, 0, 0, 0, 0);
        chk("blank_nibble", Nibble, 4'hF);

        expect_timeout();
        do_capture("tmo", 7'h40, TIMEOUT - 1, 7'h40, 0, 1, 0, 0);
        for (int i = 0; i < 6; i++) begin
            Seg = (Seg == 7'h40) ? 7'h79 : 7'h40;
            @(posedge Clock); #1;
        end
        chk("tmo_byte", Byte, 8'h2F);
        chk("tmo_busy", Busy, 0);

        // Capture held high throughout must not re-arm the wait.
        expect_accept(7'h12, 0);
        do_capture("glitch", 7'h19, STABLE + 1, 7'h12, 2, 0, 1, 0);
        chk("glitch_nibble", Nibble, 4'h5);
        chk("glitch_byte", Byte, 8'h5F);

        Seg = 7'h40; Capture = 1'b1;
        @(posedge Clock); #1;
        Capture = 1'b0;
        @(posedge Clock); #2;
        Reset = 1'b1;
        #1;
        chk("midrst_busy", Busy, 0);
        chk("midrst_nibble", Nibble, 0);
        chk("midrst_byte", Byte, 0);
        chk("midrst_pulses", {Valid, Error, ByteValid}, 0);
        @(posedge Clock); #1;
        Reset = 1'b0;
        m_nib = 4'h0; m_byte = 8'h00; m_cnt = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge Clock); #1;
            chk("midrst_quiet", Valid | Error | Busy, 0);
        end

        expect_accept(7'h24, 0);
        do_capture("re2", 7'h24, STABLE - 1, 7'h24, 0, 0, 0, 0);
        expect_accept(7'h0E, 0);
        do_capture("reF", 7'h0E, STABLE - 1, 7'h0E, 0, 0, 0, 0);
        chk("pre_clear_byte", Byte, 8'h2F);

        expect_accept(7'h08, 1);
        do_capture("clrA", 7'h08, STABLE - 1, 7'h08, 0, 0, 0, 1);
        chk("clrA_byte", Byte, 8'hA0);

        expect_accept(7'h79, 0);
        do_capture("after_clr", 7'h79, STABLE - 1, 7'h79, 0, 0, 0, 0);
        chk("after_clr_byte", Byte, 8'hA1);

        Clear = 1'b1;
        @(posedge Clock); #1;
        Clear = 1'b0;
        chk("clear_idle_byte", Byte, 8'h00);
        chk("clear_idle_nibble", Nibble, 4'h1);

        repeat (3) @(posedge Clock);
        #1;
        chk("scoreboard_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
